// File: rtl/ms_access_arbiter.sv
// Arbitrates the single memory store between the CU bus and the debug/loader port,
// sequencing each access as IDLE -> ACCESS (MEM_LAT cycles) -> RECOVER.
module ms_access_arbiter #(
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1,
    parameter int FAIR    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner_dbg
);
    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;

    state_t        state, state_nxt;
    logic          cpu_req, grant_any, grant_dbg, last_cyc;
    logic          last_dbg;
    logic [CW-1:0] cnt;

    assign cpu_req   = cpu_read | cpu_write;
    assign grant_any = cpu_req | dbg_req;
    // Debug wins only when alone, or on a tie under round-robin when CPU had the last grant.
    assign grant_dbg = dbg_req & (~cpu_req | ((FAIR != 0) & ~last_dbg));
    assign last_cyc  = (state == S_ACCESS) && (cnt == CW'(1));
    assign cpu_stall = cpu_req & ~((state == S_RECOVER) & ~owner_dbg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (grant_any) state_nxt = S_ACCESS;
            S_ACCESS:  if (last_cyc)  state_nxt = S_RECOVER;
            S_RECOVER: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            dbg_ack   <= 1'b0;
            owner_dbg <= 1'b0;
            last_dbg  <= 1'b1;
            cnt       <= '0;
        end else begin
            dbg_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        mem_en    <= 1'b1;
                        owner_dbg <= grant_dbg;
                        last_dbg  <= grant_dbg;
                        cnt       <= CW'(MEM_LAT);
                        if (grant_dbg) begin
                            mem_we    <= dbg_we;
                            mem_addr  <= dbg_addr;
                            mem_wdata <= dbg_wdata;
                        end else begin
                            // Simultaneous read and write strobes resolve to a write.
                            mem_we    <= cpu_write;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    cnt <= cnt - CW'(1);
                    if (last_cyc) begin
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        dbg_ack <= owner_dbg;
                        if (!mem_we) begin
                            if (owner_dbg) dbg_rdata <= mem_rdata;
                            else           cpu_rdata <= mem_rdata;
                        end
                    end
                end
                S_RECOVER: owner_dbg <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ms_access_arbiter.sv
// Bench for ms_access_arbiter: three instances (lat1/fair, lat3/fair, lat1/fixed) share
// stimulus; each has its own memory model, and a scoreboard checks completions.
module tb_ms_access_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_read = 1'b0, cpu_write = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [4:0] cpu_addr = '0, dbg_addr = '0;
    logic [7:0] cpu_wdata = '0, dbg_wdata = '0;

    logic [2:0]      stall, dack, men, mwe, odbg;
    logic [2:0][7:0] crd, drd, mwd, mrd;
    logic [2:0][4:0] maddr;

    int n_cmp = 0;
    int n_bad = 0;
    int act = -1;

    typedef struct {string tag; bit rd; logic [7:0] val;} exp_t;
    exp_t cq[$];
    exp_t dq[$];
    exp_t e;
    logic [7:0] shadow [3][32];

    always #5 clk = ~clk;

    ms_access_arbiter #(.AW(5), .DW(8), .MEM_LAT(1), .FAIR(1)) u_l1 (
        .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(crd[0]), .cpu_stall(stall[0]), .dbg_req(dbg_req),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dack[0]),
        .dbg_rdata(drd[0]), .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
        .mem_wdata(mwd[0]), .mem_rdata(mrd[0]), .owner_dbg(odbg[0]));

    ms_access_arbiter #(.AW(5), .DW(8), .MEM_LAT(3), .FAIR(1)) u_l3 (
        .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(crd[1]), .cpu_stall(stall[1]), .dbg_req(dbg_req),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dack[1]),
        .dbg_rdata(drd[1]), .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
        .mem_wdata(mwd[1]), .mem_rdata(mrd[1]), .owner_dbg(odbg[1]));

    ms_access_arbiter #(.AW(5), .DW(8), .MEM_LAT(1), .FAIR(0)) u_f0 (
        .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(crd[2]), .cpu_stall(stall[2]), .dbg_req(dbg_req),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dack[2]),
        .dbg_rdata(drd[2]), .mem_en(men[2]), .mem_we(mwe[2]), .mem_addr(maddr[2]),
        .mem_wdata(mwd[2]), .mem_rdata(mrd[2]), .owner_dbg(odbg[2]));

    for (genvar k = 0; k < 3; k++) begin : g_mem
        logic [7:0] ms [32];
        always @(posedge clk) if (men[k] && mwe[k]) ms[maddr[k]] <= mwd[k];
        assign mrd[k] = ms[maddr[k]];
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat(int k);
        return (k == 1) ? 3 : 1;
    endfunction

    // Scoreboard: pop on every completion the active instance reports.
    always @(negedge clk) begin
        if (act >= 0 && rst) begin
            if ((cpu_read || cpu_write) && !stall[act]) begin
                if (cq.size() == 0) chk("cpu_unexpected_done", 1, 0);
                else begin
                    e = cq.pop_front();
                    if (e.rd) chk(e.tag, crd[act], e.val);
                end
            end
            if (dack[act]) begin
                if (dq.size() == 0) chk("dbg_unexpected_ack", 1, 0);
                else begin
                    e = dq.pop_front();
                    if (e.rd) chk(e.tag, drd[act], e.val);
                end
            end
        end
    end

    task automatic do_rst();
        @(posedge clk); #1;
        rst = 1'b0; cpu_read = 0; cpu_write = 0; dbg_req = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic cpu_op(int k, bit we, logic [4:0] a, logic [7:0] d, string tag);
        int cyc = 0, en_cyc = 0;
        bit ok = 1;
        @(posedge clk); #1;
        if (we) shadow[k][a] = d;
        cq.push_back('{tag, !we, shadow[k][a]});
        cpu_read = !we; cpu_write = we; cpu_addr = a; cpu_wdata = d;
        do begin
            @(negedge clk); cyc++;
            if (men[k]) begin
                en_cyc++;
                if (maddr[k] !== a || mwe[k] !== we) ok = 0;
            end
        end while (stall[k] && cyc < 50);
        chk({tag, "_lat"}, cyc, lat(k) + 2);
        chk({tag, "_en_cycles"}, en_cyc, lat(k));
        chk({tag, "_addr_we_stable"}, ok, 1);
        @(posedge clk); #1 cpu_read = 0; cpu_write = 0;
    endtask

    task automatic dbg_op(int k, bit we, logic [4:0] a, logic [7:0] d, string tag);
        int cyc = 0;
        bit st = 0;
        @(posedge clk); #1;
        if (we) shadow[k][a] = d;
        dq.push_back('{tag, !we, shadow[k][a]});
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        do begin
            @(negedge clk); cyc++;
            if (stall[k]) st = 1;
        end while (!dack[k] && cyc < 50);
        chk({tag, "_lat"}, cyc, lat(k) + 2);
        chk({tag, "_no_stall"}, st, 0);
        @(posedge clk); #1 dbg_req = 0;
    endtask

    initial begin
        int g0[$], g2[$];
        int ncnt;
        bit p0, p2;

        // Reset state
        #12;
        chk("rst_ctrl_l1", {men[0], mwe[0], dack[0], odbg[0], stall[0]}, 0);
        chk("rst_data_l1", {crd[0], drd[0], mwd[0], 3'b0, maddr[0]}, 0);
        do_rst();
        @(negedge clk);
        chk("post_rst_ctrl_all", {men, mwe, dack, odbg, stall}, 0);

        // Basic CPU read and debug write/read on lat1
        act = 0;
        dbg_op(0, 1, 5'h0A, 8'h3C, "dbg_wr_0a");
        cpu_op(0, 0, 5'h0A, 8'h00, "cpu_rd_0a");
        dbg_op(0, 1, 5'h1F, 8'hA5, "dbg_wr_1f");
        dbg_op(0, 0, 5'h1F, 8'h00, "dbg_rd_1f");
        dbg_op(0, 1, 5'h02, 8'h11, "dbg_wr_02");
        @(negedge clk);
        chk("dbg_rdata_held_after_wr", drd[0], 8'hA5);
        cpu_op(0, 1, 5'h10, 8'hC3, "cpu_wr_10");
        cpu_op(0, 0, 5'h10, 8'h00, "cpu_rd_10");
        dbg_op(0, 0, 5'h10, 8'h00, "dbg_rd_10");

        // Debug request dropped after one cycle still completes with a single ack
        @(posedge clk); #1;
        shadow[0][5'h04] = 8'h66;
        dq.push_back('{"dbg_abort_wr", 1'b0, 8'h66});
        dbg_req = 1; dbg_we = 1; dbg_addr = 5'h04; dbg_wdata = 8'h66;
        @(posedge clk); #1 dbg_req = 0;
        repeat (6) @(negedge clk);
        chk("dbg_abort_acked_once", dq.size(), 0);
        dbg_op(0, 0, 5'h04, 8'h00, "dbg_rd_04");

        // Contention: round-robin alternates, fixed priority starves debug
        do_rst();
        act = -1;
        p0 = 0; p2 = 0; ncnt = 0;
        @(posedge clk); #1;
        cpu_read = 1; cpu_addr = 5'h0A; dbg_req = 1; dbg_we = 0; dbg_addr = 5'h1F;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (men[0] && !p0) g0.push_back(int'(odbg[0]));
            if (men[2] && !p2) g2.push_back(int'(odbg[2]));
            if (odbg[2]) ncnt++;
            p0 = men[0]; p2 = men[2];
        end
        @(posedge clk); #1 cpu_read = 0; dbg_req = 0;
        chk("rr_grant_count", (g0.size() >= 4), 1);
        for (int i = 0; i < 4 && i < g0.size(); i++) chk($sformatf("rr_grant%0d", i), g0[i], i % 2);
        chk("fixed_grant_count", (g2.size() >= 4), 1);
        chk("fixed_never_dbg", ncnt, 0);

        // Three-cycle latency CPU write and readback
        do_rst();
        act = 1;
        cpu_op(1, 1, 5'h03, 8'h77, "l3_cpu_wr_03");
        cpu_op(1, 0, 5'h03, 8'h00, "l3_cpu_rd_03");

        // Reset asserted in the second ACCESS cycle
        @(posedge clk); #1;
        dbg_req = 1; dbg_we = 1; dbg_addr = 5'h07; dbg_wdata = 8'hEE;
        ncnt = 0;
        for (int i = 0; i < 20 && ncnt < 2; i++) begin
            @(negedge clk);
            if (men[1]) ncnt++;
        end
        chk("l3_reached_access2", ncnt, 2);
        #1 rst = 1'b0;
        #1;
        chk("rst_mid_mem_en", {men[1], mwe[1], odbg[1], dack[1]}, 0);
        dbg_req = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_late_ack", dq.size(), 0);
        dbg_op(1, 1, 5'h07, 8'h5A, "l3_dbg_wr_07");
        dbg_op(1, 0, 5'h07, 8'h00, "l3_dbg_rd_07");
        cpu_op(1, 0, 5'h07, 8'h00, "l3_cpu_rd_07");

        repeat (2) @(negedge clk);
        chk("cpu_sb_drained", cq.size(), 0);
        chk("dbg_sb_drained", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
